// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, addresses InstructionMem and fills the IF/ID register.
// Optional saturating performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stalled,
    output logic [31:0] perf_flushed,
`endif
    output logic        fetch_fault
);

    localparam int unsigned ADDR_W    = 32;
    localparam logic [ADDR_W-1:0] ADDR_SPAN = ADDR_W'(4 * MEM_WORDS);
    localparam logic [ADDR_W-1:0] NOP_INSTR = 32'h0000_0000;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] pc_seq;
    logic [ADDR_W-1:0] redir_aligned;
    logic [ADDR_W-1:0] redir_target;
    logic              redir_bad;

    logic [ADDR_W-1:0] pc_d;
    logic [31:0]       instr_d;
    logic [ADDR_W-1:0] pc4_d;
    logic              valid_d;
    logic              fault_d;

    assign imem_addr = pc;

    // pc never leaves [0, ADDR_SPAN), so a single compare implements the sequential wrap.
    assign pc_plus4      = pc + ADDR_W'(4);
    assign pc_seq        = (pc_plus4 >= ADDR_SPAN) ? '0 : pc_plus4;
    assign redir_aligned = {redirect_pc[31:2], 2'b00};
    assign redir_target  = redir_aligned % ADDR_SPAN;
    assign redir_bad     = (redirect_pc[1:0] != 2'b00) || (redirect_pc >= ADDR_SPAN);

    // Next-state selection: redirect > stall > sequential.
    always_comb begin
        pc_d    = pc;
        instr_d = if_id_instr;
        pc4_d   = if_id_pc4;
        valid_d = if_id_valid;
        fault_d = fetch_fault;
        if (redirect_valid) begin
            pc_d    = redir_target;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            fault_d = fetch_fault | redir_bad;
        end else if (!stall) begin
            pc_d    = pc_seq;
            instr_d = imem_instr;
            pc4_d   = pc_seq;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc          <= RESET_PC;
            if_id_instr <= NOP_INSTR;
            if_id_pc4   <= '0;
            if_id_valid <= 1'b0;
            fetch_fault <= 1'b0;
        end else begin
            pc          <= pc_d;
            if_id_instr <= instr_d;
            if_id_pc4   <= pc4_d;
            if_id_valid <= valid_d;
            fetch_fault <= fault_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    logic fetch_evt;
    logic stall_evt;
    logic flush_evt;

    assign fetch_evt = !redirect_valid && !stall;
    assign stall_evt = !redirect_valid && stall;
    assign flush_evt = redirect_valid;

    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic evt);
        return (evt && (cnt != CNT_MAX)) ? cnt + 32'd1 : cnt;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            perf_fetched <= '0;
            perf_stalled <= '0;
            perf_flushed <= '0;
        end else begin
            perf_fetched <= sat_inc(perf_fetched, fetch_evt);
            perf_stalled <= sat_inc(perf_stalled, stall_evt);
            perf_flushed <= sat_inc(perf_flushed, flush_evt);
        end
    end
`endif

endmodule
